w5300_socket_n_rx: RTL

- Socket-n TCP receive engine, entered in the driver's Receiving state after the IRQ handler flags a RECV interrupt on socket N.
- Drives the shared w5300_interface command bus to:
  - read Sn_RX_RSR;
  - pop the PACK_INFO length word and payload words from Sn_RX_FIFOR;
  - write each payload word into the external eth_rx buffer;
  - issue the RECV command on Sn_CR.
- Reports completion to the entry FSM.

---
 rtl/w5300_socket_n_rx_pkg.sv | 20 ++
 rtl/w5300_socket_n_rx.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/w5300_socket_n_rx_pkg.sv
// W5300 socket register map, access direction codes and command bytes
// shared by the socket engines that drive the w5300_interface bus.
package W5300;

  localparam logic RD = 1'b0;
  localparam logic WR = 1'b1;

  localparam logic [9:0] SN_MR       = 10'h000;
  localparam logic [9:0] SN_CR       = 10'h002;
  localparam logic [9:0] SN_RX_RSR   = 10'h028;
  localparam logic [9:0] SN_RX_FIFOR = 10'h030;

  localparam logic [7:0] CMD_RECV = 8'h40;

  // Socket n registers occupy a 64-byte window starting at 0x200.
  function automatic logic [9:0] sn_base(input logic [2:0] n);
    return 10'h200 + {1'b0, n, 6'b000000};
  endfunction

endpackage

// File: rtl/w5300_socket_n_rx.sv
// Socket-n TCP receive engine: reads RSR, drains one packet from the RX FIFO
// into the eth_rx buffer and acknowledges it with a RECV command.
module w5300_socket_n_rx
  import W5300::*;
#(
  parameter int N                   = 0,
  parameter int ETH_RX_BUFFER_WIDTH = 16
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           start,
  output logic                           busy,
  output logic                           done,
  output logic                           overflow,
  output logic [15:0]                    pkt_len,
  output logic [10:0]                    addr,
  output logic [15:0]                    wr_data,
  input  logic [15:0]                    rd_data,
  input  logic                           op_state,
  output logic                           eth_rx_req,
  output logic [ETH_RX_BUFFER_WIDTH-1:0] eth_rx_buffer_addr,
  output logic [15:0]                    eth_rx_buffer_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RSR_HI,
    S_RSR_LO,
    S_PACK_INFO,
    S_DATA,
    S_RECV,
    S_FINISH
  } state_t;

  localparam logic [9:0] BASE = sn_base(3'(N));
  localparam int         W    = ETH_RX_BUFFER_WIDTH;

  state_t        state;
  logic          rsr_hi;
  logic [15:0]   words_left;
  logic [W:0]    wptr;
  logic [16:0]   len_plus_one;

  // Word count is ceil(len/2); bits [16:1] of len+1 give it without overflow.
  assign len_plus_one = {1'b0, rd_data} + 17'd1;

  // Transaction sequencer: wptr saturates at the buffer size, and its MSB marks a full buffer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state              <= S_IDLE;
      addr               <= {RD, BASE + SN_MR};
      wr_data            <= 16'h0000;
      busy               <= 1'b0;
      done               <= 1'b0;
      overflow           <= 1'b0;
      pkt_len            <= 16'h0000;
      eth_rx_req         <= 1'b0;
      eth_rx_buffer_addr <= {W{1'b0}};
      eth_rx_buffer_data <= 16'h0000;
      rsr_hi             <= 1'b0;
      words_left         <= 16'h0000;
      wptr               <= {(W+1){1'b0}};
    end else begin
      done       <= 1'b0;
      eth_rx_req <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            overflow <= 1'b0;
            busy     <= 1'b1;
            wptr     <= {(W+1){1'b0}};
            addr     <= {RD, BASE + SN_RX_RSR};
            state    <= S_RSR_HI;
          end
        end
        S_RSR_HI: begin
          if (op_state) begin
            rsr_hi <= rd_data[0];
            addr   <= {RD, BASE + SN_RX_RSR + 10'h002};
            state  <= S_RSR_LO;
          end
        end
        S_RSR_LO: begin
          if (op_state) begin
            if ({rsr_hi, rd_data} == 17'd0) begin
              pkt_len <= 16'h0000;
              addr    <= {RD, BASE + SN_MR};
              busy    <= 1'b0;
              done    <= 1'b1;
              state   <= S_FINISH;
            end else begin
              addr  <= {RD, BASE + SN_RX_FIFOR};
              state <= S_PACK_INFO;
            end
          end
        end
        S_PACK_INFO: begin
          if (op_state) begin
            pkt_len    <= rd_data;
            words_left <= len_plus_one[16:1];
            if (len_plus_one[16:1] == 16'h0000) begin
              addr    <= {WR, BASE + SN_CR};
              wr_data <= {8'h00, CMD_RECV};
              state   <= S_RECV;
            end else begin
              state <= S_DATA;
            end
          end
        end
        S_DATA: begin
          if (op_state) begin
            words_left <= words_left - 16'd1;
            if (!wptr[W]) begin
              eth_rx_req         <= 1'b1;
              eth_rx_buffer_addr <= wptr[W-1:0];
              eth_rx_buffer_data <= rd_data;
              wptr               <= wptr + {{W{1'b0}}, 1'b1};
            end else begin
              overflow <= 1'b1;
            end
            if (words_left == 16'd1) begin
              addr    <= {WR, BASE + SN_CR};
              wr_data <= {8'h00, CMD_RECV};
              state   <= S_RECV;
            end
          end
        end
        S_RECV: begin
          if (op_state) begin
            addr    <= {RD, BASE + SN_MR};
            wr_data <= 16'h0000;
            busy    <= 1'b0;
            done    <= 1'b1;
            state   <= S_FINISH;
          end
        end
        S_FINISH: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
